// File: rtl/jmp_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module   : jmp_redirect_unit
// Purpose  : Resolves branch conditions and jump targets for NUM_THREAD
//            hardware threads. Each thread has one registered redirect slot.
//            Pending redirects are offered to fetch round-robin over a
//            valid/ready handshake.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            i_in_valid/i_in_tid - op present this cycle and its thread
//            i_cur_pc, i_imm     - op PC (word-addressed) and signed offset
//            i_data_a            - register base for absolute jumps
//            i_jmp_con, i_eq/lt  - condition code and comparison flags
//            i_flush             - per-thread clear of the pending slot
//            i_redir_ready       - fetch accepts the offered redirect
//            o_taken, o_link_pc  - combinational condition result and PC+1
//            o_redir_valid/tid/pc- offered redirect
//            o_pending           - slot-occupied flags
//            o_drop              - one-cycle pulse: a taken op was discarded
// Revision : 1.0 - initial release
// ============================================================================
module jmp_redirect_unit #(
  parameter int              PC_W       = 32,
  parameter int              IMM_W      = 12,
  parameter int              NUM_THREAD = 4,
  parameter int              TID_W      = $clog2(NUM_THREAD),
  parameter logic [PC_W-1:0] HANDLER_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_in_valid,
  input  logic [TID_W-1:0]      i_in_tid,
  input  logic [PC_W-1:0]       i_cur_pc,
  input  logic [IMM_W-1:0]      i_imm,
  input  logic [PC_W-1:0]       i_data_a,
  input  logic [3:0]            i_jmp_con,
  input  logic                  i_eq,
  input  logic                  i_lt,
  input  logic [NUM_THREAD-1:0] i_flush,
  input  logic                  i_redir_ready,
  output logic                  o_taken,
  output logic [PC_W-1:0]       o_link_pc,
  output logic                  o_redir_valid,
  output logic [TID_W-1:0]      o_redir_tid,
  output logic [PC_W-1:0]       o_redir_pc,
  output logic [NUM_THREAD-1:0] o_pending,
  output logic                  o_drop
);

  localparam logic [3:0]      c_con_eq  = 4'b0001;
  localparam logic [3:0]      c_con_lt  = 4'b0010;
  localparam logic [3:0]      c_con_ne  = 4'b0100;
  localparam logic [3:0]      c_con_ge  = 4'b1000;
  localparam logic [3:0]      c_con_rel = 4'b0111;
  localparam logic [3:0]      c_con_abs = 4'b1111;
  localparam logic [PC_W-1:0] c_one     = 1;
  localparam logic [TID_W-1:0] c_tid_one = 1;

  logic [PC_W-1:0]       r_target [NUM_THREAD];
  logic [NUM_THREAD-1:0] r_pending;
  logic [TID_W-1:0]      r_rr_ptr;
  logic                  r_lock;
  logic [TID_W-1:0]      r_lock_tid;
  logic                  r_drop;

  logic                  w_cond;
  logic [PC_W-1:0]       w_sext_imm;
  logic [PC_W-1:0]       w_target;
  logic [TID_W-1:0]      w_rr_tid;
  logic                  w_rr_found;
  logic [TID_W-1:0]      w_grant_tid;
  logic                  w_valid;
  logic                  w_hs;
  logic                  w_slot_free;
  logic                  w_write;
  logic                  w_discard;
  logic [NUM_THREAD-1:0] w_pending_nxt;

  // Condition decode
  always_comb begin
    w_cond = 1'b0;
    case (i_jmp_con)
      c_con_eq:  w_cond = i_eq;
      c_con_lt:  w_cond = i_lt;
      c_con_ne:  w_cond = ~i_eq;
      c_con_ge:  w_cond = ~i_lt;
      c_con_rel: w_cond = 1'b1;
      c_con_abs: w_cond = 1'b1;
      default:   w_cond = 1'b0;
    endcase
  end

  assign o_taken    = i_in_valid & w_cond;
  assign o_link_pc  = i_cur_pc + c_one;
  assign w_sext_imm = {{(PC_W-IMM_W){i_imm[IMM_W-1]}}, i_imm};
  // Only the register-absolute form uses data_a; every other taken form
  // is relative to the fall-through PC.
  assign w_target   = (i_jmp_con == c_con_abs) ? (i_data_a + w_sext_imm)
                                               : (o_link_pc + w_sext_imm);

  // Round-robin search over pending slots starting at r_rr_ptr
  always_comb begin
    logic [TID_W-1:0] v_idx;
    v_idx      = '0;
    w_rr_tid   = '0;
    w_rr_found = 1'b0;
    for (int i = 0; i < NUM_THREAD; i++) begin
      v_idx = r_rr_ptr + TID_W'(i);
      if (!w_rr_found && r_pending[v_idx]) begin
        w_rr_tid   = v_idx;
        w_rr_found = 1'b1;
      end
    end
  end

  // A stalled grant stays fixed; the locked slot cannot change target
  // because writes to an occupied, unpopped slot are discarded.
  assign w_grant_tid = r_lock ? r_lock_tid : w_rr_tid;
  assign w_valid     = |r_pending;
  assign w_hs        = w_valid & i_redir_ready;

  // A slot popped this cycle may be refilled in the same cycle.
  assign w_slot_free = ~r_pending[i_in_tid] | (w_hs & (w_grant_tid == i_in_tid));
  assign w_write     = o_taken & ~i_flush[i_in_tid] &  w_slot_free;
  assign w_discard   = o_taken & ~i_flush[i_in_tid] & ~w_slot_free;

  // Flush is applied last so it overrides both pop and write.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_hs)
      w_pending_nxt[w_grant_tid] = 1'b0;
    if (w_write)
      w_pending_nxt[i_in_tid] = 1'b1;
    w_pending_nxt = w_pending_nxt & ~i_flush;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending  <= '0;
      r_rr_ptr   <= '0;
      r_lock     <= 1'b0;
      r_lock_tid <= '0;
      r_drop     <= 1'b0;
    end else begin
      r_pending  <= w_pending_nxt;
      // Lock only while stalled and the granted slot survives this edge.
      r_lock     <= w_valid & ~i_redir_ready & ~i_flush[w_grant_tid];
      r_lock_tid <= w_grant_tid;
      r_drop     <= w_discard;
      if (w_hs)
        r_rr_ptr <= w_grant_tid + c_tid_one;
    end
  end

  // Target storage needs no reset: it is only observed while pending.
  always_ff @(posedge clk) begin
    if (w_write)
      r_target[i_in_tid] <= w_target;
  end

  assign o_redir_valid = w_valid;
  assign o_redir_tid   = w_valid ? w_grant_tid : '0;
  assign o_redir_pc    = w_valid ? r_target[w_grant_tid] : HANDLER_PC;
  assign o_pending     = r_pending;
  assign o_drop        = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_jmp_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_jmp_redirect_unit
// Purpose  : Self-checking bench for jmp_redirect_unit: directed scenarios
//            with literal expectations followed by random traffic checked
//            against a slot/queue-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jmp_redirect_unit;

  localparam int          N   = 4;
  localparam logic [31:0] HPC = 32'hDEAD_0000;

  logic        clk;
  logic        rst;
  logic        i_in_valid;
  logic [1:0]  i_in_tid;
  logic [31:0] i_cur_pc;
  logic [11:0] i_imm;
  logic [31:0] i_data_a;
  logic [3:0]  i_jmp_con;
  logic        i_eq;
  logic        i_lt;
  logic [3:0]  i_flush;
  logic        i_redir_ready;
  logic        o_taken;
  logic [31:0] o_link_pc;
  logic        o_redir_valid;
  logic [1:0]  o_redir_tid;
  logic [31:0] o_redir_pc;
  logic [3:0]  o_pending;
  logic        o_drop;

  jmp_redirect_unit #(
    .PC_W(32), .IMM_W(12), .NUM_THREAD(N), .TID_W(2), .HANDLER_PC(HPC)
  ) dut (
    .clk(clk), .rst(rst),
    .i_in_valid(i_in_valid), .i_in_tid(i_in_tid), .i_cur_pc(i_cur_pc),
    .i_imm(i_imm), .i_data_a(i_data_a), .i_jmp_con(i_jmp_con),
    .i_eq(i_eq), .i_lt(i_lt), .i_flush(i_flush),
    .i_redir_ready(i_redir_ready),
    .o_taken(o_taken), .o_link_pc(o_link_pc),
    .o_redir_valid(o_redir_valid), .o_redir_tid(o_redir_tid),
    .o_redir_pc(o_redir_pc), .o_pending(o_pending), .o_drop(o_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit          m_known = 0;
  bit          m_pend [N];
  logic [31:0] m_tgt  [N];
  int          m_rr;
  bit          m_lock;
  int          m_lock_tid;
  bit          m_drop;

  // Expectations for the cycle being applied
  bit          e_taken;
  logic [31:0] e_target;
  bit          e_valid;
  int          e_grant;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit cond_true(input logic [3:0] c, input bit e, input bit l);
    case (c)
      4'b0001: return e;
      4'b0010: return l;
      4'b0100: return !e;
      4'b1000: return !l;
      4'b0111: return 1'b1;
      4'b1111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Compute expectations from model state and current inputs, then compare.
  task automatic check_model();
    logic [31:0] sx;
    logic [3:0]  pend_vec;
    sx       = {{20{i_imm[11]}}, i_imm};
    e_taken  = i_in_valid && cond_true(i_jmp_con, i_eq, i_lt);
    e_target = (i_jmp_con == 4'b1111) ? i_data_a + sx : i_cur_pc + 32'd1 + sx;
    chk("taken", o_taken, e_taken);
    chk("link_pc", o_link_pc, i_cur_pc + 32'd1);
    e_valid  = 0;
    e_grant  = 0;
    pend_vec = '0;
    for (int t = 0; t < N; t++) begin
      pend_vec[t] = m_pend[t];
      if (m_pend[t]) e_valid = 1;
    end
    if (m_lock) e_grant = m_lock_tid;
    else begin
      for (int k = N - 1; k >= 0; k--)
        if (m_pend[(m_rr + k) % N]) e_grant = (m_rr + k) % N;
    end
    if (m_known) begin
      chk("redir_valid", o_redir_valid, e_valid);
      chk("pending", o_pending, pend_vec);
      chk("drop", o_drop, m_drop);
      if (e_valid) begin
        chk("redir_tid", o_redir_tid, e_grant);
        chk("redir_pc", o_redir_pc, m_tgt[e_grant]);
      end else begin
        chk("redir_pc_idle", o_redir_pc, HPC);
      end
    end
  endtask

  task automatic apply(input bit v, input int tid, input logic [31:0] pc,
                       input logic [11:0] imm, input logic [31:0] da,
                       input logic [3:0] con, input bit e, input bit l,
                       input logic [3:0] fl, input bit rdy, input bit r);
    i_in_valid    = v;
    i_in_tid      = tid[1:0];
    i_cur_pc      = pc;
    i_imm         = imm;
    i_data_a      = da;
    i_jmp_con     = con;
    i_eq          = e;
    i_lt          = l;
    i_flush       = fl;
    i_redir_ready = rdy;
    rst           = r;
    #1;
    check_model();
  endtask

  // Advance the model by one clock edge according to the current inputs.
  task automatic advance();
    bit old [N];
    bit hs;
    int t;
    if (rst) begin
      m_known = 1;
      for (int k = 0; k < N; k++) m_pend[k] = 0;
      m_rr = 0; m_lock = 0; m_lock_tid = 0; m_drop = 0;
    end else if (m_known) begin
      for (int k = 0; k < N; k++) old[k] = m_pend[k];
      hs = e_valid && i_redir_ready;
      t  = int'(i_in_tid);
      m_drop = 0;
      if (hs) m_pend[e_grant] = 0;
      if (e_taken && !i_flush[t]) begin
        if (!old[t] || (hs && e_grant == t)) begin
          m_pend[t] = 1;
          m_tgt[t]  = e_target;
        end else begin
          m_drop = 1;
        end
      end
      for (int k = 0; k < N; k++) if (i_flush[k]) m_pend[k] = 0;
      m_lock     = e_valid && !i_redir_ready && !i_flush[e_grant];
      m_lock_tid = e_grant;
      if (hs) m_rr = (e_grant + 1) % N;
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit rdy);
    apply(0, 0, 32'h0, 12'h0, 32'h0, 4'b0000, 0, 0, 4'b0000, rdy, 0);
  endtask

  // Unconditional relative jump with imm=0: target = pc + 1
  task automatic jmp(input int tid, input logic [31:0] pc, input bit rdy);
    apply(1, tid, pc, 12'h0, 32'h0, 4'b0111, 0, 0, 4'b0000, rdy, 0);
  endtask

  initial begin
    logic [3:0] cons [6];
    logic [3:0] con;
    cons[0] = 4'b0001; cons[1] = 4'b0010; cons[2] = 4'b0100;
    cons[3] = 4'b1000; cons[4] = 4'b0111; cons[5] = 4'b1111;

    @(negedge clk);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); advance();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); advance();

    // Reset state
    idle(0);
    chk("rst_valid", o_redir_valid, 0);
    chk("rst_tid", o_redir_tid, 0);
    chk("rst_pc", o_redir_pc, HPC);
    chk("rst_pending", o_pending, 0);
    chk("rst_drop", o_drop, 0);
    advance();

    // Conditional eq branch with negative offset
    apply(1, 2, 32'h100, 12'hFFE, 0, 4'b0001, 1, 0, 0, 0, 0);
    chk("t1_taken", o_taken, 1);
    chk("t1_link", o_link_pc, 32'h101);
    advance();
    idle(1);
    chk("t1_valid", o_redir_valid, 1);
    chk("t1_tid", o_redir_tid, 2);
    chk("t1_pc", o_redir_pc, 32'hFF);
    advance();
    idle(0);
    chk("t1_popped", o_pending, 0);
    advance();

    // Register-absolute jump, then a ge branch with lt=1 (not taken)
    apply(1, 0, 32'h500, 12'h010, 32'h2000, 4'b1111, 0, 0, 0, 0, 0); advance();
    apply(1, 1, 32'h600, 12'h005, 0, 4'b1000, 0, 1, 0, 0, 0);
    chk("t2_ge_taken", o_taken, 0);
    chk("t2_abs_pc", o_redir_pc, 32'h2010);
    advance();
    idle(0);
    chk("t2_pending", o_pending, 4'b0001);
    advance();
    idle(1); advance();

    // Burst with ready high: grants 0, 1, 3
    jmp(0, 32'h10, 1); advance();
    jmp(1, 32'h20, 1);
    chk("t3_g0", o_redir_tid, 0);
    advance();
    jmp(3, 32'h30, 1);
    chk("t3_g1", o_redir_tid, 1);
    chk("t3_pc1", o_redir_pc, 32'h21);
    advance();
    idle(1);
    chk("t3_g3", o_redir_tid, 3);
    chk("t3_pc3", o_redir_pc, 32'h31);
    advance();
    idle(1);
    chk("t3_empty", o_redir_valid, 0);
    advance();

    // Stall hold: slot 1 offered, slot 0 fills behind it
    jmp(1, 32'h40, 0); advance();
    jmp(0, 32'h50, 0);
    chk("t4_tid_a", o_redir_tid, 1);
    chk("t4_pc_a", o_redir_pc, 32'h41);
    advance();
    idle(0);
    chk("t4_tid_b", o_redir_tid, 1);
    chk("t4_pc_b", o_redir_pc, 32'h41);
    chk("t4_pending", o_pending, 4'b0011);
    advance();
    idle(1);
    chk("t4_hs_tid", o_redir_tid, 1);
    advance();
    idle(1);
    chk("t4_next_tid", o_redir_tid, 0);
    chk("t4_next_pc", o_redir_pc, 32'h51);
    advance();

    // Write to occupied slot: discarded, then replaced on same-cycle pop
    jmp(2, 32'h60, 0); advance();
    jmp(2, 32'h70, 0); advance();
    idle(0);
    chk("t5_drop", o_drop, 1);
    chk("t5_keep_pc", o_redir_pc, 32'h61);
    advance();
    idle(0);
    chk("t5_drop_pulse", o_drop, 0);
    advance();
    jmp(2, 32'h80, 1);
    chk("t5_pop_tid", o_redir_tid, 2);
    advance();
    idle(1);
    chk("t5_refill", o_pending, 4'b0100);
    chk("t5_no_drop", o_drop, 0);
    chk("t5_new_pc", o_redir_pc, 32'h81);
    advance();
    idle(0); advance();

    // Flush beats a same-cycle write
    jmp(2, 32'h90, 0); advance();
    apply(1, 2, 32'hA0, 0, 0, 4'b0111, 0, 0, 4'b0100, 0, 0); advance();
    idle(0);
    chk("t6_flush_pend", o_pending, 0);
    chk("t6_flush_drop", o_drop, 0);
    advance();

    // Reset during stall
    jmp(1, 32'hB0, 0); advance();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); advance();
    idle(1);
    chk("t6_rst_valid", o_redir_valid, 0);
    chk("t6_rst_pc", o_redir_pc, HPC);
    advance();

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int sel;
      sel = $urandom_range(0, 6);
      con = (sel == 6) ? 4'($urandom) : cons[sel];
      apply($urandom_range(0, 1), $urandom_range(0, N - 1),
            $urandom, 12'($urandom), $urandom, con,
            $urandom_range(0, 1), $urandom_range(0, 1),
            4'($urandom & $urandom & $urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 199) == 0);
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jmp_redirect_unit.md
Name: jmp_redirect_unit

Overview:
- Parametrised successor to the branch/jump target calculator.
- Resolves branch conditions and jump targets for up to NUM_THREAD hardware threads.
- Holds at most one pending redirect per thread in a registered slot.
- Round-robin arbitrates pending redirects to fetch over a valid/ready handshake; sits between execute and the fetch PC-select logic.

Parameters:
- PC_W, 32, width of PC, data_a and target.
- IMM_W, 12, immediate width; sign-extended to PC_W.
- NUM_THREAD, 4, number of threads and slots (power of two, ≥2).
- TID_W, $clog2(NUM_THREAD), thread-id width.
- HANDLER_PC, 0, value driven on redir_pc when redir_valid=0.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  a branch/jump op is present this cycle.
- in_tid  in  TID_W  thread of the op.
- cur_pc  in  PC_W  PC of the op (word-addressed).
- imm  in  IMM_W  signed offset.
- data_a  in  PC_W  register base for absolute jump.
- jmp_con  in  4  condition code.
- eq  in  1  operands equal.
- lt  in  1  operand a less than operand b.
- flush  in  NUM_THREAD  per-thread clear of the pending slot.
- redir_ready  in  1  fetch accepts redirect.
- taken  out  1  combinational: condition true for the current op.
- link_pc  out  PC_W  combinational cur_pc+1.
- redir_valid  out  1  a redirect is offered.
- redir_tid  out  TID_W  thread of the offered redirect.
- redir_pc  out  PC_W  target of the offered redirect.
- pending  out  NUM_THREAD  slot-occupied flags.
- drop  out  1  registered one-cycle pulse: a taken op was discarded.

Behaviour:
- Condition decode (taken is gated by in_valid):
  - 0001: taken if eq.
  - 0010: taken if lt.
  - 0100: taken if !eq.
  - 1000: taken if !lt (new, ge).
  - 0111: unconditional PC-relative.
  - 1111: unconditional register-absolute.
  - All other codes: not taken.
- Targets:
  - Relative target = cur_pc + 1 + sext(imm).
  - Absolute target = data_a + sext(imm).
  - Arithmetic is modulo 2^PC_W; wrap is silent.
- Latency:
  - Taken op at edge N writes slot[in_tid] with the target and sets pending.
  - redir_valid can first be seen in cycle N+1.
  - Not-taken ops change no state.
- Arbitration:
  - Round-robin over the pending slots, starting at rr_ptr.
  - On handshake (redir_valid & redir_ready), rr_ptr becomes granted tid + 1, modulo NUM_THREAD.
- Stall hold:
  - While redir_valid & !redir_ready, the grant is latched.
  - redir_tid and redir_pc must stay stable until the handshake, even if other slots fill.
  - The latched grant is released by handshake, by flush of the granted thread, or by rst.
- Pop: a handshake clears pending[redir_tid] at the edge.
- Write to an occupied slot:
  - If the slot is popped that same cycle, the write lands and pending stays 1 with the new target.
  - Otherwise the new op is discarded, the slot keeps the older target, and drop=1 in the next cycle.
- Flush:
  - flush[t] clears slot t at the edge.
  - Flush beats a same-cycle write to t; the write is discarded and drop is not asserted.
  - If t is the offered slot, redir_valid may still be 1 that cycle. A handshake in that cycle is valid, and the slot still ends cleared.
- redir outputs:
  - redir_valid = |pending.
  - redir_pc = HANDLER_PC when redir_valid=0.
- Reset values: all slots empty, pending=0, rr_ptr=0, lock cleared, redir_valid=0, redir_tid=0, redir_pc=HANDLER_PC, drop=0.
- Reset mid-stall discards all slots; no redirect is issued afterwards.

Test Plan:
- in_valid, tid=2, cur_pc=0x100, imm=0xFFE, jmp_con=0001, eq=1 → taken=1, link_pc=0x101. Next cycle: redir_valid=1, tid=2, pc=0xFF; redir_ready=1 → pending=0.
- jmp_con=1111, data_a=0x2000, imm=0x010 → redir_pc=0x2010. Then jmp_con=1000 with lt=1 → taken=0, no state change.
- Slots 0, 1, 3 filled in one burst with redir_ready=1 → grants in order 0, 1, 3. rr_ptr=0 again afterwards.
- redir_ready=0 with slot 1 offered, then slot 0 filled → redir_tid stays 1 and redir_pc stays unchanged until ready.
- Slot 2 pending and not popped, new taken op to tid 2 → slot keeps old pc, drop=1 for one cycle. Same case with redir_ready=1 popping slot 2 → new pc replaces the old one, drop=0.
- flush[2] with a same-cycle write to tid 2 → pending[2]=0, drop=0. rst during stall → redir_valid=0 and redir_pc=HANDLER_PC the next cycle.
